ram_access_ctrl: RTL

Multi-cycle controller between the MEM pipeline stage and the external 16-bit asynchronous SRAM. It produces the memory read data that the writeback mux selects for MEM_READ instructions. It sequences SRAM read and write cycles with the correct enable/output-enable/write-enable ordering. It stalls the pipeline until each access completes.

---
 rtl/ram_access_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - multi-cycle MEM-stage controller for a 16-bit asynchronous SRAM
module ram_access_ctrl #(
    parameter int         WAIT_CYC = 1,
    parameter logic [1:0] ADDR_HI  = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        stall,
    output logic        done,
    output logic [17:0] ram_addr,
    inout  wire  [15:0] ram_data,
    output logic        ram_en_n,
    output logic        ram_oe_n,
    output logic        ram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] wdata_q;
    logic        drive;

    // Strobes and bus enable are registered so they reflect the current state;
    // the asynchronous reset releases WE and the bus without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rdata    <= 16'h0000;
            done     <= 1'b0;
            ram_addr <= 18'h0;
            wdata_q  <= 16'h0000;
            drive    <= 1'b0;
            ram_en_n <= 1'b1;
            ram_oe_n <= 1'b1;
            ram_we_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_write) begin
                        state    <= WR_SETUP;
                        ram_addr <= {ADDR_HI, addr};
                        wdata_q  <= wdata;
                        drive    <= 1'b1;
                        ram_en_n <= 1'b0;
                    end else if (mem_read) begin
                        state    <= RD;
                        ram_addr <= {ADDR_HI, addr};
                        cnt      <= CNT_LOAD;
                        ram_en_n <= 1'b0;
                        ram_oe_n <= 1'b0;
                    end
                end
                RD: begin
                    if (cnt == 4'd0) begin
                        rdata    <= ram_data;
                        state    <= DONE;
                        done     <= 1'b1;
                        ram_en_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_SETUP: begin
                    state    <= WR_PULSE;
                    cnt      <= CNT_LOAD;
                    ram_we_n <= 1'b0;
                end
                WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        state    <= WR_HOLD;
                        ram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_HOLD: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    drive    <= 1'b0;
                    ram_en_n <= 1'b1;
                end
                DONE: begin
                    // Requests are ignored here so a still-held request cannot restart.
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_data = drive ? wdata_q : 16'hzzzz;
    assign stall    = (mem_read | mem_write) & ~done;

endmodule
